// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory bus between fetch_stage and the instruction memory
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    // fetch stage drives the address and receives combinational read data
    modport master (
        output imem_addr,
        input  imem_rdata
    );

    // instruction memory answers the address combinationally
    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS32 IF stage: PC, 2-bit BHT predictor (FETCH_BHT_EN), IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_stage_if.master     imem,
    input  logic              if_id_pc_write,
    input  logic              if_id_write_from_hazard_detector,
    input  logic              pridictor_wrong,
    input  logic [31:0]       ex_redirect_pc,
    input  logic              ex_branch_valid,
    input  logic              ex_branch_taken,
    input  logic [31:0]       ex_branch_pc,
    output logic [31:0]       instruction,
    output logic [31:0]       if_id_pc_plus4,
    output logic [1:0]        if_id_branch_pridictor_bit
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [1:0]  ctr;

    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + 32'd4;

`ifdef FETCH_BHT_EN
    logic [1:0]     bht [BHT_ENTRIES];
    logic [IDX-1:0] rd_idx;
    logic [IDX-1:0] wr_idx;
    logic           is_branch;
    logic           pred_taken;
    logic [31:0]    br_offset;
    logic           unused_ex_pc;

    assign rd_idx       = pc[IDX+1:2];
    assign wr_idx       = ex_branch_pc[IDX+1:2];
    // beq (000100) and bne (000101) share the upper five opcode bits
    assign is_branch    = (imem.imem_rdata[31:27] == 5'b00010);
    // lookup reads the stored value; a same-cycle update is not bypassed
    assign ctr          = bht[rd_idx];
    assign pred_taken   = is_branch && ctr[1];
    assign br_offset    = {{14{imem.imem_rdata[15]}}, imem.imem_rdata[15:0], 2'b00};
    assign next_pc      = pred_taken ? (pc_plus4 + br_offset) : pc_plus4;
    assign unused_ex_pc = ^{ex_branch_pc[31:IDX+2], ex_branch_pc[1:0]};

    // saturating counter training from EX; independent of stall and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (ex_branch_valid) begin
            if (ex_branch_taken) begin
                if (bht[wr_idx] != 2'b11) begin
                    bht[wr_idx] <= bht[wr_idx] + 2'd1;
                end
            end else begin
                if (bht[wr_idx] != 2'b00) begin
                    bht[wr_idx] <= bht[wr_idx] - 2'd1;
                end
            end
        end
    end
`else
    logic unused_ex;

    // static not-taken prediction; branch resolution feedback has no consumer
    assign ctr       = 2'b01;
    assign next_pc   = pc_plus4;
    assign unused_ex = ^{ex_branch_valid, ex_branch_taken, ex_branch_pc};
`endif

    // PC: redirect beats stall, stall beats predicted next PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (pridictor_wrong) begin
            pc <= ex_redirect_pc;
        end else if (if_id_pc_write) begin
            pc <= next_pc;
        end
    end

    // IF/ID register: flush to a nop on mispredict, otherwise load unless stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction                <= 32'h0;
            if_id_pc_plus4             <= 32'h0;
            if_id_branch_pridictor_bit <= 2'b01;
        end else if (pridictor_wrong) begin
            instruction                <= 32'h0;
            if_id_pc_plus4             <= 32'h0;
            if_id_branch_pridictor_bit <= 2'b01;
        end else if (if_id_write_from_hazard_detector) begin
            instruction                <= imem.imem_rdata;
            if_id_pc_plus4             <= pc_plus4;
            if_id_branch_pridictor_bit <= ctr;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_id_pc_write;
    logic        if_id_write_from_hazard_detector;
    logic        pridictor_wrong;
    logic [31:0] ex_redirect_pc;
    logic        ex_branch_valid;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_pc;
    logic [31:0] instruction;
    logic [31:0] if_id_pc_plus4;
    logic [1:0]  if_id_branch_pridictor_bit;

    logic [31:0] mem [64];
    int total = 0;
    int bad = 0;

    fetch_stage_if bus ();

    assign bus.imem_rdata = mem[bus.imem_addr[7:2]];

    fetch_stage dut (
        .clk                              (clk),
        .rst_n                            (rst_n),
        .imem                             (bus),
        .if_id_pc_write                   (if_id_pc_write),
        .if_id_write_from_hazard_detector (if_id_write_from_hazard_detector),
        .pridictor_wrong                  (pridictor_wrong),
        .ex_redirect_pc                   (ex_redirect_pc),
        .ex_branch_valid                  (ex_branch_valid),
        .ex_branch_taken                  (ex_branch_taken),
        .ex_branch_pc                     (ex_branch_pc),
        .instruction                      (instruction),
        .if_id_pc_plus4                   (if_id_pc_plus4),
        .if_id_branch_pridictor_bit       (if_id_branch_pridictor_bit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hA000_0000 | i;
        end
        mem[8] = 32'h1000_0004;

        rst_n = 1'b0;
        if_id_pc_write = 1'b1;
        if_id_write_from_hazard_detector = 1'b1;
        pridictor_wrong = 1'b0;
        ex_redirect_pc = 32'h0;
        ex_branch_valid = 1'b0;
        ex_branch_taken = 1'b0;
        ex_branch_pc = 32'h0;
        tick();
        tick();

        // reset state
        check("rst_addr",  bus.imem_addr, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc4",   if_id_pc_plus4, 32'h0);
        check("rst_bits",  {30'h0, if_id_branch_pridictor_bit}, 32'h1);

        // sequential fetch
        rst_n = 1'b1;
        check("seq_addr0", bus.imem_addr, 32'h0);
        tick();
        check("seq_addr4", bus.imem_addr, 32'h4);
        check("seq_instr0", instruction, 32'hA000_0000);
        check("seq_pc4_0", if_id_pc_plus4, 32'h4);
        tick();
        check("seq_addr8", bus.imem_addr, 32'h8);
        check("seq_instr1", instruction, 32'hA000_0001);

        // load-use stall for two cycles at PC 8
        if_id_pc_write = 1'b0;
        if_id_write_from_hazard_detector = 1'b0;
        tick();
        check("stall1_addr", bus.imem_addr, 32'h8);
        check("stall1_instr", instruction, 32'hA000_0001);
        tick();
        check("stall2_addr", bus.imem_addr, 32'h8);
        check("stall2_pc4", if_id_pc_plus4, 32'h8);
        if_id_pc_write = 1'b1;
        if_id_write_from_hazard_detector = 1'b1;
        tick();
        check("resume_addr", bus.imem_addr, 32'hC);
        check("resume_instr", instruction, 32'hA000_0002);
        tick();
        check("seq_addr16", bus.imem_addr, 32'h10);

        // mispredict while stalled at PC 16
        if_id_pc_write = 1'b0;
        if_id_write_from_hazard_detector = 1'b0;
        pridictor_wrong = 1'b1;
        ex_redirect_pc = 32'h40;
        tick();
        pridictor_wrong = 1'b0;
        if_id_pc_write = 1'b1;
        if_id_write_from_hazard_detector = 1'b1;
        check("flush_addr", bus.imem_addr, 32'h40);
        check("flush_instr", instruction, 32'h0);
        check("flush_pc4", if_id_pc_plus4, 32'h0);
        check("flush_bits", {30'h0, if_id_branch_pridictor_bit}, 32'h1);
        tick();
        check("redir_addr", bus.imem_addr, 32'h44);
        check("redir_instr", instruction, 32'hA000_0010);

        // train beq at 0x20 taken twice, the second resolution redirects to it
        ex_branch_valid = 1'b1;
        ex_branch_taken = 1'b1;
        ex_branch_pc = 32'h20;
        tick();
        pridictor_wrong = 1'b1;
        ex_redirect_pc = 32'h20;
        tick();
        pridictor_wrong = 1'b0;
        ex_branch_valid = 1'b0;
        check("train_addr", bus.imem_addr, 32'h20);
        tick();
        check("train_instr", instruction, 32'h1000_0004);
        check("train_pc4", if_id_pc_plus4, 32'h24);
`ifdef FETCH_BHT_EN
        check("train_bits", {30'h0, if_id_branch_pridictor_bit}, 32'h3);
        check("train_target", bus.imem_addr, 32'h34);
`else
        check("train_bits", {30'h0, if_id_branch_pridictor_bit}, 32'h1);
        check("train_target", bus.imem_addr, 32'h24);
`endif

        // three not-taken resolutions on entry of 0x10, then fetch it
        ex_branch_valid = 1'b1;
        ex_branch_taken = 1'b0;
        ex_branch_pc = 32'h10;
        tick();
        tick();
        pridictor_wrong = 1'b1;
        ex_redirect_pc = 32'h10;
        tick();
        pridictor_wrong = 1'b0;
        check("sat_addr", bus.imem_addr, 32'h10);
        // same-cycle taken update and fetch of that index
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_valid = 1'b0;
        check("same_instr", instruction, 32'hA000_0004);
`ifdef FETCH_BHT_EN
        check("same_bits", {30'h0, if_id_branch_pridictor_bit}, 32'h0);
`else
        check("same_bits", {30'h0, if_id_branch_pridictor_bit}, 32'h1);
`endif
        pridictor_wrong = 1'b1;
        ex_redirect_pc = 32'h10;
        tick();
        pridictor_wrong = 1'b0;
        tick();
        check("post_bits", {30'h0, if_id_branch_pridictor_bit}, 32'h1);
        check("post_addr", bus.imem_addr, 32'h14);

        // asynchronous reset in mid-operation
        rst_n = 1'b0;
        #1;
        check("arst_addr", bus.imem_addr, 32'h0);
        check("arst_instr", instruction, 32'h0);
        rst_n = 1'b1;
        tick();
        check("rel_addr", bus.imem_addr, 32'h4);
        check("rel_instr", instruction, 32'hA000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS32 pipeline, directly upstream of the decode/register-file stage. Owns the PC, a branch history table (BHT) of 2-bit saturating counters, and the IF/ID pipeline register. It supplies `instruction` and `if_id_branch_pridictor_bit` to decode. It honours the hazard detector's stall enables and redirects on EX-stage mispredicts.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `BHT_ENTRIES`, default 16: number of BHT counters; power of two, at least 2. Index bits `IDX = log2(BHT_ENTRIES)`.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `if_id_pc_write` input 1: 1 lets the PC advance; 0 holds it (load-use stall).
- `if_id_write_from_hazard_detector` input 1: 1 lets IF/ID load; 0 holds it.
- `pridictor_wrong` input 1: EX resolved a mispredicted branch this cycle.
- `ex_redirect_pc` input 32: correct next PC, valid while `pridictor_wrong` is 1.
- `ex_branch_valid` input 1: a beq/bne is resolving in EX this cycle.
- `ex_branch_taken` input 1: actual outcome of that branch.
- `ex_branch_pc` input 32: PC of that branch.
- `imem_addr` output 32: current PC, drives instruction memory.
- `imem_rdata` input 32: combinational instruction-memory read data for `imem_addr`.
- `instruction` output 32: IF/ID instruction register.
- `if_id_pc_plus4` output 32: IF/ID copy of PC+4.
- `if_id_branch_pridictor_bit` output 2: IF/ID copy of the BHT counter used for this fetch.

## Operation
- Predecode of `imem_rdata`: opcode [31:26] equal to 6'b000100 (beq) or 6'b000101 (bne) marks a branch.
- Lookup: `ctr = bht[imem_addr[IDX+1:2]]`. The branch is predicted taken when it is a branch and `ctr[1]` is 1.
- Next PC when predicted taken: `pc+4 + {sext(imm16), 2'b00}`. Otherwise `pc+4`. All arithmetic is 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is allowed and not flagged.
- PC update priority:
  1. `pridictor_wrong` loads `ex_redirect_pc`. This overrides a stall.
  2. Otherwise, `if_id_pc_write` = 0 holds the PC.
  3. Otherwise, the PC loads the predicted next PC.
- IF/ID update priority:
  1. `pridictor_wrong` flushes IF/ID: `instruction` = 32'h0 (nop), `if_id_pc_plus4` = 0, predictor bits = 2'b01.
  2. Otherwise, `if_id_write_from_hazard_detector` = 0 holds all three registers.
  3. Otherwise, IF/ID loads `imem_rdata`, `pc+4`, and `ctr`.
- BHT update: when `ex_branch_valid` is 1, update entry `ex_branch_pc[IDX+1:2]`.
  - Taken: counter becomes min(ctr+1, 3).
  - Not taken: counter becomes max(ctr−1, 0).
  - The update happens regardless of stall or flush.
- Same-index read and update in one cycle: the lookup sees the old value. The new value is visible from the next cycle. There is no bypass.
- Counter meaning: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.

## Timing
- Reset (asynchronous, immediate):
  - PC = `RESET_PC`.
  - `instruction` = 0, `if_id_pc_plus4` = 0, `if_id_branch_pridictor_bit` = 2'b01.
  - All BHT entries = 2'b01.
- `imem_addr` equals the PC register with zero combinational delay.
- Fetch-to-decode latency: one cycle. A word fetched in cycle N appears on `instruction` in cycle N+1.
- Mispredict: the redirect PC is fetched in the cycle after the `pridictor_wrong` edge. The wrong-path word sitting in IF at that edge is discarded by the flush. Squashing the decode-stage instruction is the decode stage's job.
- Stall: with both enables at 0 for K cycles, the PC and IF/ID hold for exactly K cycles. `imem_addr` stays stable during the stall.
- Deasserting reset in mid-operation is permitted at any time. The first fetch after release is at `RESET_PC`.

## Configuration
- `FETCH_BHT_EN` defined: dynamic prediction via the BHT as described above.
- `FETCH_BHT_EN` undefined:
  - No BHT storage is built.
  - The block always predicts not-taken: next PC = `pc+4`.
  - `if_id_branch_pridictor_bit` is constant 2'b01.
  - `ex_branch_*` inputs are ignored.
  - Redirect, flush and stall behaviour are unchanged.

## Test plan
- Reset and sequential fetch: release reset with `RESET_PC` = 0 and no branches in memory. `imem_addr` must read 0, 4, 8, 12 on successive cycles, and `instruction` must equal the memory word fetched one cycle earlier.
- Load-use stall: at PC = 8, drive both enables to 0 for 2 cycles. `imem_addr` must stay at 8 for 2 cycles, IF/ID must hold, and fetch must resume at 12.
- Mispredict flush: at PC = 16, pulse `pridictor_wrong` with `ex_redirect_pc` = 32'h40 while enables are 0. Next cycle `imem_addr` must be 32'h40, `instruction` must be 0, and predictor bits must be 2'b01.
- BHT training: train a beq at PC 32'h20 with imm 16'h0004 by resolving it taken twice. The next fetch of 32'h20 must show counter 2'b11 and `imem_addr` must jump to 32'h34.
- Saturation and same-cycle update: resolve not-taken 3 times on an entry holding 01; the counter must go 00 and stay 00. Then update and fetch the same index in one cycle; the fetch must carry the pre-update value.
- `FETCH_BHT_EN` undefined: repeat the BHT-training stimulus. The fetch must go to 32'h24, and predictor bits must stay 2'b01.
